// File: rtl/vga_timing_if.sv
// Output bundle of the VGA timing generator: sync, display enable, coordinates
// and line/frame strobes. The r/g/b test-pattern channels exist only when
// VGA_TEST_PATTERN_EN is defined.
interface vga_timing_if #(
  parameter int unsigned CNT_W = 10
);

  logic             hsync;
  logic             vsync;
  logic             de;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic [4:0]       r;
  logic [5:0]       g;
  logic [4:0]       b;
`endif

`ifdef VGA_TEST_PATTERN_EN
  modport master (
    output hsync, vsync, de, x, y, line_start, frame_start, r, g, b
  );
  modport slave (
    input  hsync, vsync, de, x, y, line_start, frame_start, r, g, b
  );
`else
  modport master (
    output hsync, vsync, de, x, y, line_start, frame_start
  );
  modport slave (
    input  hsync, vsync, de, x, y, line_start, frame_start
  );
`endif

endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-timing generator for raster displays (default 640x480@60, 800x525 total).
// Free-running h/v counters; every output is registered one stage after the
// counters, so outputs at a clock edge describe the counter pair held before it.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar RGB565 colour-bar pattern.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master vga_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries pre-cast to counter width so all compares are same-width.
  localparam logic [CNT_W-1:0] HMax     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VMax     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HActive  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActive  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HsStart  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HsEnd    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VsStart  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VsEnd    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // Counter next state: h wraps at H_TOTAL-1, v steps on h wrap and wraps at V_TOTAL-1.
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HMax) begin
      h_d = '0;
      if (v_q == VMax) begin
        v_d = '0;
      end else begin
        v_d = v_q + 1'b1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Decode the current counter pair into the next registered output values.
  always_comb begin
    de_d          = (h_q < HActive) && (v_q < VActive);
    hsync_d       = ((h_q >= HsStart) && (h_q < HsEnd)) ? HS_POL : ~HS_POL;
    // v only changes at h==0, so vsync is inherently line-aligned.
    vsync_d       = ((v_q >= VsStart) && (v_q < VsEnd)) ? VS_POL : ~VS_POL;
    line_start_d  = (h_q == '0);
    frame_start_d = (h_q == '0) && (v_q == '0);
  end

  // Output stage: one clock behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= h_q;
      y_q           <= v_q;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.de          = de_q;
  assign vga_o.x           = x_q;
  assign vga_o.y           = y_q;
  assign vga_o.line_start  = line_start_q;
  assign vga_o.frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  logic [4:0] r_q, r_d;
  logic [5:0] g_q, g_d;
  logic [4:0] b_q, b_d;

  // Bar index by comparing h against constant bar edges; no divider needed.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_q >= CNT_W'(k * BAR_W)) begin
        bar_idx = 3'(k);
      end
    end
  end

  // Bar colours: white, yellow, cyan, green, magenta, red, blue, black; blank outside de.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de_d) begin
      case (bar_idx)
        3'd0:    begin r_d = '1; g_d = '1; b_d = '1; end
        3'd1:    begin r_d = '1; g_d = '1; b_d = '0; end
        3'd2:    begin r_d = '0; g_d = '1; b_d = '1; end
        3'd3:    begin r_d = '0; g_d = '1; b_d = '0; end
        3'd4:    begin r_d = '1; g_d = '0; b_d = '1; end
        3'd5:    begin r_d = '1; g_d = '0; b_d = '0; end
        3'd6:    begin r_d = '0; g_d = '0; b_d = '1; end
        default: begin r_d = '0; g_d = '0; b_d = '0; end
      endcase
    end
  end

  // Colour registers share the output stage with de.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign vga_o.r = r_q;
  assign vga_o.g = g_q;
  assign vga_o.b = b_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing uses the 640x480 defaults;
// vertical timing is shortened (6/2/2/3 = 13 lines, 10400 clocks per frame) so
// full frames, the double wrap and vsync placement fit in a short run.
module tb_vga_timing_gen;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned V_ACT   = 6;
  localparam int unsigned V_TOT   = 13;
  localparam int unsigned H_TOT   = 800;
  localparam int unsigned F_CLKS  = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int failures = 0;

  vga_timing_if #(.CNT_W(CNT_W)) vga_if ();

  vga_timing_gen #(
    .H_ACTIVE (640),
    .H_FP     (16),
    .H_SYNC   (96),
    .H_BP     (48),
    .V_ACTIVE (V_ACT),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3),
    .HS_POL   (1'b0),
    .VS_POL   (1'b0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga_o (vga_if)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one output cycle and sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, 32'(vga_if.x), 0);
    chk({tag, "_y"}, 32'(vga_if.y), 0);
    chk({tag, "_de"}, 32'(vga_if.de), 0);
    chk({tag, "_ls"}, 32'(vga_if.line_start), 0);
    chk({tag, "_fs"}, 32'(vga_if.frame_start), 0);
    chk({tag, "_hs"}, 32'(vga_if.hsync), 1);
    chk({tag, "_vs"}, 32'(vga_if.vsync), 1);
`ifdef VGA_TEST_PATTERN_EN
    chk({tag, "_rgb"}, 32'({vga_if.r, vga_if.g, vga_if.b}), 0);
`endif
  endtask

  task automatic chk_origin(input string tag);
    chk({tag, "_x"}, 32'(vga_if.x), 0);
    chk({tag, "_y"}, 32'(vga_if.y), 0);
    chk({tag, "_de"}, 32'(vga_if.de), 1);
    chk({tag, "_ls"}, 32'(vga_if.line_start), 1);
    chk({tag, "_fs"}, 32'(vga_if.frame_start), 1);
    chk({tag, "_hs"}, 32'(vga_if.hsync), 1);
    chk({tag, "_vs"}, 32'(vga_if.vsync), 1);
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, hs_last, ls_cnt;
    int vs_cnt, vs_fx, vs_fy, vs_lx, vs_ly, de_bad, y_max, cyc, px, py;
    bit done;

    // Reset held with clock running.
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_hold");

    // Release; first output cycle shows the origin.
    rst_n = 1'b1;
    tick();
    chk_origin("first");

    // Line 0: 800 samples starting at x=0.
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) tick();
      chk("x_seq", 32'(vga_if.x), 32'(i));
      if (vga_if.de) de_cnt++;
      if (vga_if.line_start) ls_cnt++;
      if (!vga_if.hsync) begin
        if (hs_first < 0) hs_first = int'(vga_if.x);
        hs_last = int'(vga_if.x);
        hs_cnt++;
      end
      if (i == 639) chk("de_x639", 32'(vga_if.de), 1);
      if (i == 640) chk("de_x640", 32'(vga_if.de), 0);
`ifdef VGA_TEST_PATTERN_EN
      if (i == 0)   chk("rgb_x0", 32'({vga_if.r, vga_if.g, vga_if.b}), 32'({5'd31, 6'd63, 5'd31}));
      if (i == 80)  chk("rgb_x80", 32'({vga_if.r, vga_if.g, vga_if.b}), 32'({5'd31, 6'd63, 5'd0}));
      if (i == 160) chk("rgb_x160", 32'({vga_if.r, vga_if.g, vga_if.b}), 32'({5'd0, 6'd63, 5'd31}));
      if (i == 400) chk("rgb_x400", 32'({vga_if.r, vga_if.g, vga_if.b}), 32'({5'd31, 6'd0, 5'd0}));
      if (i == 639) chk("rgb_x639", 32'({vga_if.r, vga_if.g, vga_if.b}), 0);
      if (i == 700) begin
        chk("rgb_x700", 32'({vga_if.r, vga_if.g, vga_if.b}), 0);
        chk("de_x700", 32'(vga_if.de), 0);
      end
`endif
    end
    chk("line_de_cnt", 32'(de_cnt), 640);
    chk("line_hs_cnt", 32'(hs_cnt), 96);
    chk("line_hs_first", 32'(hs_first), 656);
    chk("line_hs_last", 32'(hs_last), 751);
    chk("line_ls_cnt", 32'(ls_cnt), 1);

    // Second line begins exactly 800 clocks after the first.
    tick();
    chk("l1_x", 32'(vga_if.x), 0);
    chk("l1_y", 32'(vga_if.y), 1);
    chk("l1_ls", 32'(vga_if.line_start), 1);
    chk("l1_fs", 32'(vga_if.frame_start), 0);

    // Rest of the frame until the next frame_start, bounded.
    vs_cnt = 0; vs_fx = -1; vs_fy = -1; vs_lx = -1; vs_ly = -1;
    de_bad = 0; y_max = 0; cyc = 800; px = -1; py = -1; done = 1'b0;
    while (!done && cyc < 2 * F_CLKS) begin
      if (!vga_if.vsync) begin
        if (vs_fx < 0) begin
          vs_fx = int'(vga_if.x);
          vs_fy = int'(vga_if.y);
        end
        vs_lx = int'(vga_if.x);
        vs_ly = int'(vga_if.y);
        vs_cnt++;
      end
      if (vga_if.de && vga_if.y >= CNT_W'(V_ACT)) de_bad++;
      if (int'(vga_if.y) > y_max) y_max = int'(vga_if.y);
      px = int'(vga_if.x);
      py = int'(vga_if.y);
      tick();
      cyc++;
      if (vga_if.frame_start) done = 1'b1;
    end
    chk("frame_period", 32'(cyc), 32'(F_CLKS));
    chk("vs_cnt", 32'(vs_cnt), 1600);
    chk("vs_first_x", 32'(vs_fx), 0);
    chk("vs_first_y", 32'(vs_fy), 8);
    chk("vs_last_x", 32'(vs_lx), 799);
    chk("vs_last_y", 32'(vs_ly), 9);
    chk("de_in_vblank", 32'(de_bad), 0);
    chk("y_max", 32'(y_max), 12);
    chk("wrap_prev_x", 32'(px), 799);
    chk("wrap_prev_y", 32'(py), 12);
    chk_origin("wrap");

    // Move to x=300, y=2 then pulse reset between clock edges.
    for (int i = 0; i < 1900; i++) tick();
    chk("mid_x", 32'(vga_if.x), 300);
    chk("mid_y", 32'(vga_if.y), 2);
    #5;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_mid_hold");
    rst_n = 1'b1;
    tick();
    chk_origin("restart");
    tick();
    chk("restart_x1", 32'(vga_if.x), 1);
    chk("restart_y1", 32'(vga_if.y), 0);
    chk("restart_fs1", 32'(vga_if.frame_start), 0);
    chk("restart_ls1", 32'(vga_if.line_start), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
